// File: rtl/ecs_seq_pkg.sv
// Shared types and widths for the ECS trigger sequencer.
// Holds the sequencer state enum and the data, counter and decimation widths.
package ecs_seq_pkg;

    localparam int DATA_W = 18;
    localparam int CNT_W  = 16;
    localparam int DEC_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ecs_sat_counter.sv
// Saturating status counter. It stops at all-ones and never wraps.
// A clear takes priority over an increment in the same cycle.
module ecs_sat_counter
    import ecs_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/ecs_trigger_sequencer.sv
// ECS trigger sequencer: decimates PWM carrier events into SPI conversion starts and latches the results.
// Define ECS_SEQ_TIMEOUT_EN to build in the conversion watchdog (timeout_cycles / timeout_err).
module ecs_trigger_sequencer
    import ecs_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              trig_on_high,
    input  logic              trig_on_low,
    input  logic              carrier_high,
    input  logic              carrier_low,
    input  logic [DEC_W-1:0]  decim,
    input  logic [15:0]       timeout_cycles,
    input  logic              clr_status,
    output logic              spi_trigger,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_data_x,
    input  logic [DATA_W-1:0] spi_data_y,
    output logic [DATA_W-1:0] data_x,
    output logic [DATA_W-1:0] data_y,
    output logic              data_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  overrun_cnt,
    output logic              timeout_err
);

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [DEC_W-1:0] dec_cnt;
    logic             spi_done_q;
    logic             qual;
    logic             fire;
    logic             done_rise;
    logic             timeout_hit;

    // Peak and valley in the same cycle collapse into a single event.
    assign qual      = enable & ((carrier_high & trig_on_high) | (carrier_low & trig_on_low));
    assign fire      = qual & (dec_cnt == decim);
    assign done_rise = spi_done & ~spi_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt    <= '0;
            spi_done_q <= 1'b0;
        end else begin
            spi_done_q <= spi_done;
            if (!enable) begin
                dec_cnt <= '0;
            end else if (qual) begin
                dec_cnt <= fire ? '0 : dec_cnt + DEC_W'(1);
            end
        end
    end

`ifdef ECS_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic [15:0] wd_nxt;

    // wd_nxt is the number of WAIT cycles including the current one; a done edge wins a tie.
    assign wd_nxt      = wd_cnt + 16'd1;
    assign timeout_hit = (state == WAIT) && (timeout_cycles != 16'd0) &&
                         (wd_nxt == timeout_cycles) && !done_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (clr_status) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic [15:0] unused_timeout_cycles;

    assign unused_timeout_cycles = timeout_cycles;
    assign timeout_hit           = 1'b0;
    assign timeout_err           = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        spi_trigger = 1'b0;
        data_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (fire) state_nxt = ISSUE;
            end
            ISSUE: begin
                spi_trigger = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_nxt = LATCH;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            LATCH: begin
                data_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Capture on the accepted edge so the new words are visible in the same cycle as data_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_x <= '0;
            data_y <= '0;
        end else if ((state == WAIT) && done_rise) begin
            data_x <= spi_data_x;
            data_y <= spi_data_y;
        end
    end

    ecs_sat_counter #(
        .W(CNT_W)
    ) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (data_valid),
        .clr   (clr_status),
        .cnt   (sample_cnt)
    );

    ecs_sat_counter #(
        .W(CNT_W)
    ) u_overrun_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fire & busy),
        .clr   (clr_status),
        .cnt   (overrun_cnt)
    );

endmodule

// File: doc/ecs_trigger_sequencer.md
ECS_TRIGGER_SEQUENCER -- requirements
Module: ecs_trigger_sequencer

Interface
REQ-001 SHALL have port clk  in  1  rising-edge system clock (200 MHz AXI clock).
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port enable  in  1  level; 0 stops new conversions, in-flight conversion completes.
REQ-004 SHALL have ports trig_on_high, trig_on_low  in  1 each  select the PWM carrier events that qualify.
REQ-005 SHALL have ports carrier_high, carrier_low  in  1 each  one-cycle PWM carrier peak/valley pulses.
REQ-006 SHALL have port decim  in  8  fire one conversion every decim+1 qualifying events.
REQ-007 SHALL have port timeout_cycles  in  16  conversion watchdog in clk cycles; 0 disables the watchdog.
REQ-008 SHALL have port clr_status  in  1  one-cycle pulse that clears the status counters and the error flag.
REQ-009 SHALL have port spi_trigger  out  1  one-cycle start pulse to the SPI master.
REQ-010 SHALL have port spi_done  in  1  done level from the SPI master; cleared by the master after a start, set when data is valid.
REQ-011 SHALL have ports spi_data_x, spi_data_y  in  18 each  sensor words from the SPI master.
REQ-012 SHALL have ports data_x, data_y  out  18 each  last completed sample, held between updates.
REQ-013 SHALL have port data_valid  out  1  one-cycle pulse when data_x/data_y update.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have ports sample_cnt, overrun_cnt  out  16 each  saturating status counters.
REQ-016 SHALL have port timeout_err  out  1  sticky watchdog-expiry flag.

Function
REQ-017 SHALL define qual = enable & ((carrier_high & trig_on_high) | (carrier_low & trig_on_low)); carrier_high and carrier_low in the same cycle count as one event.
REQ-018 SHALL keep an 8-bit dec_cnt: on qual, if dec_cnt==decim then fire=1 and dec_cnt<=0, else dec_cnt<=dec_cnt+1; dec_cnt advances in every state; enable=0 forces dec_cnt<=0.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, LATCH.
REQ-020 IDLE: on fire, go to ISSUE; otherwise stay.
REQ-021 ISSUE: spi_trigger=1 for exactly this cycle, clear the watchdog count, go to WAIT; fire at cycle N gives spi_trigger at N+1.
REQ-022 WAIT: a rising edge of spi_done (spi_done=1, previous-cycle spi_done=0) goes to LATCH; spi_done edges in other states are ignored.
REQ-023 LATCH: register data_x<=spi_data_x and data_y<=spi_data_y, pulse data_valid, increment sample_cnt, go to IDLE; the edge at cycle M gives data_valid at M+1.
REQ-024 A fire outside IDLE SHALL be dropped and SHALL increment overrun_cnt.
REQ-025 Counters SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-026 clr_status SHALL zero sample_cnt, overrun_cnt and timeout_err; it wins over a simultaneous increment or set.
REQ-027 A late spi_done edge after a timeout abort SHALL be accepted only if it arrives while the block is in WAIT for a later conversion.

Reset
REQ-028 During rst_n=0 the block SHALL enter IDLE and SHALL drive spi_trigger=0, data_valid=0, busy=0, timeout_err=0.
REQ-029 During rst_n=0 data_x, data_y, sample_cnt, overrun_cnt, dec_cnt, the watchdog count and the spi_done edge register SHALL all be 0.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion without a data_valid pulse.

Configuration
REQ-031 With macro ECS_SEQ_TIMEOUT_EN defined, WAIT SHALL count clk cycles.
REQ-032 With ECS_SEQ_TIMEOUT_EN defined, a count equal to a nonzero timeout_cycles SHALL set timeout_err and return to IDLE without a data_valid pulse.
REQ-033 Without ECS_SEQ_TIMEOUT_EN, there SHALL be no watchdog logic, WAIT SHALL wait indefinitely, timeout_err SHALL be tied to 0, and timeout_cycles SHALL be unused.

Structure
REQ-034 Package ecs_seq_pkg SHALL hold the state enum, DATA_W=18, CNT_W=16 and DEC_W=8.
REQ-035 Sub-module ecs_sat_counter (CNT_W-bit, inc/clr inputs, clear priority, saturating) SHALL be instantiated twice, for sample_cnt and overrun_cnt.

Verification
REQ-036 Bench SHALL check: decim=0, trig_on_high=1, one carrier_high -> spi_trigger 1 cycle later; spi_done rises with x=0x2AAAA, y=0x15555 -> data_x=0x2AAAA, data_y=0x15555, data_valid at the next cycle, sample_cnt=1.
REQ-037 Bench SHALL check: decim=3, 8 qualifying carrier_high pulses with fast done -> exactly 2 spi_trigger pulses (on events 4 and 8).
REQ-038 Bench SHALL check: two fires 10 cycles apart with done delayed 100 cycles -> 1 spi_trigger, overrun_cnt=1.
REQ-039 Bench SHALL check (ECS_SEQ_TIMEOUT_EN): timeout_cycles=50 and done never rises -> timeout_err=1 51 cycles after spi_trigger, busy=0, no data_valid; then clr_status -> timeout_err=0.
REQ-040 Bench SHALL check: overrun_cnt preloaded to 0xFFFF plus a further overrun -> stays 0xFFFF; clr_status in the same cycle -> 0.
REQ-041 Bench SHALL check: rst_n low during WAIT -> all outputs 0 immediately, no data_valid after release.
